// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the streaming bit-reversal reorder buffer.
package fft_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_e;

   localparam int DEF_SAMPLES = 4;

   // Floor of 1 keeps pointer vectors legal even for degenerate frame lengths.
   function automatic int addr_w(input int samples);
      return (samples < 2) ? 1 : $clog2(samples);
   endfunction

   localparam int DEF_ADDR_W = addr_w(DEF_SAMPLES);

   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < nbits) r[nbits-1-i] = idx[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// rtl/fft_bitrev_bank.sv - one storage bank of the reorder buffer with its own fill/drain state.
module fft_bitrev_bank
   import fft_pkg::*;
#(
   parameter int SAMPLES = 4,
   parameter int WIDTH   = 3,
   localparam int ADDR_W = addr_w(SAMPLES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic              wr_last_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic              rd_last_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o,
   output logic              writable_o,
   output logic              readable_o
);

   bank_state_e state_q, state_d;
   logic [WIDTH-1:0] mem_q [SAMPLES];

   always_comb begin
      state_d = state_q;
      case (state_q)
         BANK_EMPTY:    if (wr_en_i) state_d = wr_last_i ? BANK_FULL : BANK_FILLING;
         BANK_FILLING:  if (wr_en_i && wr_last_i) state_d = BANK_FULL;
         BANK_FULL:     if (rd_en_i) state_d = rd_last_i ? BANK_EMPTY : BANK_DRAINING;
         BANK_DRAINING: if (rd_en_i && rd_last_i) state_d = BANK_EMPTY;
         default:       state_d = BANK_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BANK_EMPTY;
      else        state_q <= state_d;
   end

   // Sample storage carries no reset; validity is tracked solely by state_q.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   assign rd_data_o  = mem_q[rd_addr_i];
   assign writable_o = (state_q == BANK_EMPTY) || (state_q == BANK_FILLING);
   assign readable_o = (state_q == BANK_FULL)  || (state_q == BANK_DRAINING);

endmodule

// File: rtl/fft_bitrev_stream.sv
// rtl/fft_bitrev_stream.sv - ping-pong bit-reversal reorder buffer, natural order in, bit-reversed out.
// Optional frame-length check (in_last / frame_err) is built when FFT_BITREV_FRAMECHK_EN is defined.
module fft_bitrev_stream
   import fft_pkg::*;
#(
   parameter int SAMPLES = 4,
   parameter int WIDTH   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef FFT_BITREV_FRAMECHK_EN
   input  logic             in_last,
   output logic             frame_err,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   localparam int ADDR_W = addr_w(SAMPLES);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLES - 1);

   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_fire, rd_fire, wr_wrap, rd_wrap;
   logic [1:0]        bank_writable, bank_readable;
   logic [WIDTH-1:0]  bank_rd_data [2];

   assign in_ready  = bank_writable[wr_bank_q];
   assign out_valid = bank_readable[rd_bank_q];
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;
   assign wr_wrap   = (wr_ptr_q == LAST_IDX);
   assign rd_wrap   = (rd_ptr_q == LAST_IDX);
   assign rd_addr   = ADDR_W'(bitrev(32'(rd_ptr_q), ADDR_W));
   assign out_data  = bank_rd_data[rd_bank_q];
   assign out_last  = out_valid && rd_wrap;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_bitrev_bank #(
         .SAMPLES (SAMPLES),
         .WIDTH   (WIDTH)
      ) u_bank (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_en_i    (wr_fire && (wr_bank_q == 1'(b))),
         .wr_last_i  (wr_wrap),
         .wr_addr_i  (wr_ptr_q),
         .wr_data_i  (in_data),
         .rd_en_i    (rd_fire && (rd_bank_q == 1'(b))),
         .rd_last_i  (rd_wrap),
         .rd_addr_i  (rd_addr),
         .rd_data_o  (bank_rd_data[b]),
         .writable_o (bank_writable[b]),
         .readable_o (bank_readable[b])
      );
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      rd_ptr_d  = rd_ptr_q;
      rd_bank_d = rd_bank_q;
      if (wr_fire) begin
         wr_ptr_d = wr_wrap ? '0 : wr_ptr_q + 1'b1;
         if (wr_wrap) wr_bank_d = ~wr_bank_q;
      end
      if (rd_fire) begin
         rd_ptr_d = rd_wrap ? '0 : rd_ptr_q + 1'b1;
         if (rd_wrap) rd_bank_d = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_ptr_q  <= '0;
         rd_bank_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         wr_bank_q <= wr_bank_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_bank_q <= rd_bank_d;
      end
   end

`ifdef FFT_BITREV_FRAMECHK_EN
   // Framing is still by count; in_last is only cross-checked against it.
   logic frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             frame_err_q <= 1'b0;
      else if (wr_fire && (in_last != wr_wrap)) frame_err_q <= 1'b1;
   end

   assign frame_err = frame_err_q;
`endif

endmodule
